// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, controller
// states and the power-on word pattern.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Word k of the standard pattern holds 4*(k+1).
  function automatic logic [31:0] init_word(input int unsigned k);
    return 32'((k + 1) * 4);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a fetched big-endian word and
// sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,      // byte at offset 0 sits in [31:24]
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[31:24];
    case (offset_i)
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      2'd3:    byte_sel = word_i[7:0];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];

    data_o = word_i;
    case (size_i)
      SZ_B:    data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory with registered loads, access fault
// detection and a post-reset sequencer that writes the standard word pattern.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        size,
  input  logic              loadUnsigned,
  input  logic [31:0]       writeMData,
  output logic [31:0]       readMData,
  output logic              readValid,
  output logic              fault,
  output logic              busy
);

  localparam int WORDS  = DEPTH_BYTES / 4;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int BYTE_W = $clog2(DEPTH_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             fault_q, fault_d;

  logic             in_init, req, misaligned, out_of_range, illegal;
  logic             do_store, do_load;
  logic [1:0]       offset;
  logic [IDX_W-1:0] acc_idx, wr_idx;
  logic [31:0]      init_val, fetched, load_val;

  assign offset       = address[1:0];
  assign acc_idx      = address[BYTE_W-1:2];
  assign out_of_range = (address >> BYTE_W) != '0;
  assign in_init      = (state_q == ST_INIT);
  assign req          = memRead | memWrite;

  always_comb begin
    misaligned = 1'b1;
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = offset[0];
      SZ_W:    misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign illegal  = misaligned | out_of_range;
  assign do_store = !in_init && memWrite && !illegal;
  assign do_load  = !in_init && memRead && !memWrite && !illegal;
  assign init_val = init_word(32'(init_ptr_q));
  assign wr_idx   = in_init ? init_ptr_q : acc_idx;

  // One byte bank per big-endian lane; lane 0 holds the byte at offset 0.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank_q [WORDS];
    logic       we;
    logic [7:0] wd;

    always_comb begin
      we = 1'b0;
      wd = writeMData[7:0];
      if (in_init) begin
        we = 1'b1;
        wd = init_val[31-8*gi -: 8];
      end else if (do_store) begin
        case (size)
          SZ_W: begin
            we = 1'b1;
            wd = writeMData[31-8*gi -: 8];
          end
          SZ_H: begin
            we = (offset == 2'(gi & 2));
            wd = ((gi % 2) == 0) ? writeMData[15:8] : writeMData[7:0];
          end
          SZ_B:    we = (offset == 2'(gi));
          default: we = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (we && rst_n) begin
        bank_q[wr_idx] <= wd;
      end
    end

    assign fetched[31-8*gi -: 8] = bank_q[acc_idx];
  end

  load_extend u_load_extend (
    .word_i     (fetched),
    .offset_i   (offset),
    .size_i     (size),
    .unsigned_i (loadUnsigned),
    .data_o     (load_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT_EN ? ST_INIT : ST_READY;
      init_ptr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    fault_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        fault_d  = req & illegal;
        rvalid_d = do_load;
        if (do_load) begin
          rdata_d = load_val;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign readMData = rdata_q;
  assign readValid = rvalid_q;
  assign fault     = fault_q;
  assign busy      = in_init;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, synchronous, byte-addressed big-endian data memory for the MEM stage of the MIPS pipeline. It supports byte, half and word stores, and signed or unsigned byte and half loads. Reads are registered, with one-cycle latency and a valid strobe. Misaligned, out-of-range and reserved-size accesses raise a fault. After every reset, a built-in init sequencer loads the standard word pattern before the block accepts accesses.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, multiple of 4.
ADDR_W, 32, width of the address port.
INIT_EN, 1, 1 = run the init sequencer after reset; 0 = go straight to READY with contents undefined.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst_n  in  1  synchronous, active-low reset.
memRead  in  1  load request for this cycle.
memWrite  in  1  store request for this cycle.
address  in  ADDR_W  byte address.
size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
loadUnsigned  in  1  1 = zero-extend byte/half loads; 0 = sign-extend.
writeMData  in  32  store data, right-justified (byte uses [7:0], half uses [15:0]).
readMData  out  32  load result, extended to 32 bits.
readValid  out  1  one-cycle pulse: readMData holds a new load result.
fault  out  1  one-cycle pulse: the previous cycle's access was rejected.
busy  out  1  high while in INIT; the pipeline must stall.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- rst_n low at posedge:
  - state <= INIT (READY if INIT_EN=0), init_ptr <= 0.
  - readMData <= 0, readValid <= 0, fault <= 0.
  - Any in-flight read result is dropped.
- busy = (state == INIT); it is 1 from the first edge after reset.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes word k = init_ptr at byte address 4k, value 4*(k+1), big-endian.
  - Example: bytes 0..3 = 00 00 00 04.
  - init_ptr increments each cycle; after word DEPTH_BYTES/4-1 is written, state <= READY.
  - busy is high for exactly DEPTH_BYTES/4 cycles.
  - memRead/memWrite are ignored; no readValid, no fault.
  - rst_n low mid-INIT restarts at init_ptr = 0.
- READY, access legality (evaluated only when memRead or memWrite is 1):
  - A request is illegal if: size == 11; or word with address[1:0] != 0; or half with address[0] != 0; or address >= DEPTH_BYTES.
  - Illegal request: no memory change; fault = 1 next cycle; readValid stays 0; readMData holds its value.
- Store (memWrite = 1, legal), committed at posedge, big-endian:
  - word: mem[a..a+3] = wd[31:24], wd[23:16], wd[15:8], wd[7:0].
  - half: mem[a] = wd[15:8], mem[a+1] = wd[7:0].
  - byte: mem[a] = wd[7:0].
  - No other byte changes.
- Load (memRead = 1, memWrite = 0, legal):
  - Bytes are sampled at posedge; readMData/readValid are updated at the same edge and are visible the next cycle.
  - Byte and half results are extended per loadUnsigned; a word ignores loadUnsigned.
- memRead and memWrite both 1: treated as a store only; no readValid.
- Read-after-write: a load issued the cycle after a store to an overlapping address returns the new data. A same-cycle conflict cannot occur.
- Outputs when idle:
  - readValid and fault are 0 in any cycle not following a legal or illegal access, respectively.
  - readMData holds its last value.
- Address bits above log2(DEPTH_BYTES) are used only for the range check.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_RSV;
  - the state encoding ST_INIT, ST_READY;
  - function init_word(k) returning 4*(k+1).
- One sub-module, load_extend: combinational.
  - Inputs: the 4 fetched bytes, address[1:0], size, loadUnsigned.
  - Output: the 32-bit extended load value.
- The alignment and range check stays inline.

Test Plan:
- Reset, DEPTH_BYTES = 1024: rst_n low for 2 cycles, then high.
  - busy is high for 256 cycles, then low.
  - lw 0x000 → 0x00000004; lw 0x3FC → 0x00000400; readValid pulses once per load.
- sw 0x10 = 0xDEADBEEF, then loads at 0x10–0x12:
  - lw 0x10 → 0xDEADBEEF; lb 0x10 → 0xFFFFFFDE; lbu 0x11 → 0x000000AD.
  - lh 0x12 → 0xFFFFBEEF; lhu 0x12 → 0x0000BEEF.
- sb 0x21 = 0x...AA over init word 0x20 (value 0x24) → lw 0x20 = 0x00AA0024; sh 0x22 = 0x1234 → lw 0x20 = 0x00AA1234.
- Faults:
  - lw 0x22, sh 0x13 and size = 11 each → fault pulse one cycle later, readValid = 0, lw 0x10 still 0xDEADBEEF.
  - lw 0x400 → fault.
- memRead = memWrite = 1, sw 0x30 = 0x55 → no readValid; the next lw 0x30 → 0x00000055.
- rst_n low at init cycle 100 and again during a pending lw:
  - readValid = 0 and busy re-asserts.
  - The full 256-cycle init reruns, and word 0x10 reads 0x00000014 again.
